// File: rtl/controlador_taps_filtro_pkg.sv
// rtl/controlador_taps_filtro_pkg.sv - state encodings shared by the filter tap controllers
package controlador_taps_filtro_pkg;

    localparam int BITS_ESTADO = 2;

    typedef enum logic [BITS_ESTADO-1:0] {
        EST_REPOSO   = 2'd0,
        EST_LIMPIAR  = 2'd1,
        EST_ACUMULAR = 2'd2,
        EST_FIN      = 2'd3
    } estado_t;

endpackage

// File: rtl/registro_desplazador_carga.sv
// rtl/registro_desplazador_carga.sv - one-hot left shifter with synchronous load and reset
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset, loads INICIO_REG
//   cargar     - synchronous load of INICIO_REG (has priority over desplazar)
//   desplazar  - shift left by one position
//   datos      - register contents
module registro_desplazador_carga #(
    parameter int                    BITS_DATOS = 5,
    parameter logic [BITS_DATOS-1:0] INICIO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cargar,
    input  logic                  desplazar,
    output logic [BITS_DATOS-1:0] datos
);

    always_ff @(posedge clk) begin
        if (reset || cargar) begin
            datos <= INICIO_REG;
        end else if (desplazar) begin
            datos <= {datos[BITS_DATOS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/controlador_taps_filtro.sv
// rtl/controlador_taps_filtro.sv - sequencer for one filter output (clear, then one MAC per tap)
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   iniciar             - start request, only looked at in REPOSO
//   detener             - datapath stall, only acts in ACUMULAR
//   seleccion_tap       - one-hot tap select for coefficient/sample muxes
//   indice_tap          - binary index of the active tap
//   limpiar_acumulador  - MAC accumulator clear (LIMPIAR)
//   habilitar_mac       - MAC accumulate enable (ACUMULAR and not stalled)
//   ocupado             - high outside REPOSO
//   terminado           - single-cycle completion pulse (FIN)
module controlador_taps_filtro
    import controlador_taps_filtro_pkg::*;
#(
    parameter int NUM_TAPS    = 5,
    parameter int BITS_INDICE = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   detener,
    output logic [NUM_TAPS-1:0]    seleccion_tap,
    output logic [BITS_INDICE-1:0] indice_tap,
    output logic                   limpiar_acumulador,
    output logic                   habilitar_mac,
    output logic                   ocupado,
    output logic                   terminado
);

    localparam logic [BITS_INDICE-1:0] ULTIMO_TAP = BITS_INDICE'(NUM_TAPS - 1);

    estado_t estado, estado_sig;

    logic avance;      // non-stalled accumulate cycle
    logic ultimo_tap;
    logic cargar_sel;
    logic desplazar_sel;

    assign avance     = (estado == EST_ACUMULAR) && !detener;
    assign ultimo_tap = (indice_tap == ULTIMO_TAP);

    // The select is reloaded both on entry (LIMPIAR) and on leaving the last
    // tap, so it rests at bit 0 while idle and never shifts out to zero.
    assign cargar_sel    = (estado == EST_LIMPIAR) || (avance && ultimo_tap);
    assign desplazar_sel = avance && !ultimo_tap;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= EST_REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            EST_REPOSO:   if (iniciar) estado_sig = EST_LIMPIAR;
            EST_LIMPIAR:  estado_sig = EST_ACUMULAR;
            EST_ACUMULAR: if (avance && ultimo_tap) estado_sig = EST_FIN;
            EST_FIN:      estado_sig = EST_REPOSO;
            default:      estado_sig = EST_REPOSO;
        endcase
    end

    always_comb begin
        limpiar_acumulador = (estado == EST_LIMPIAR);
        habilitar_mac      = avance;
        ocupado            = (estado != EST_REPOSO);
        terminado          = (estado == EST_FIN);
    end

    // Index counter tracks the shifter so seleccion_tap == 1 << indice_tap.
    always_ff @(posedge clk) begin
        if (reset || cargar_sel) begin
            indice_tap <= '0;
        end else if (desplazar_sel) begin
            indice_tap <= indice_tap + 1'b1;
        end
    end

    registro_desplazador_carga #(
        .BITS_DATOS (NUM_TAPS),
        .INICIO_REG (NUM_TAPS'(1))
    ) u_registro_seleccion (
        .clk       (clk),
        .reset     (reset),
        .cargar    (cargar_sel),
        .desplazar (desplazar_sel),
        .datos     (seleccion_tap)
    );

endmodule

// File: tb/tb_controlador_taps_filtro.sv
// tb/tb_controlador_taps_filtro.sv - scoreboard bench for controlador_taps_filtro
module tb_controlador_taps_filtro;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       detener;
    logic [4:0] seleccion_tap;
    logic [2:0] indice_tap;
    logic       limpiar_acumulador;
    logic       habilitar_mac;
    logic       ocupado;
    logic       terminado;

    always #5 clk = ~clk;

    controlador_taps_filtro #(
        .NUM_TAPS    (N),
        .BITS_INDICE (3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .iniciar            (iniciar),
        .detener            (detener),
        .seleccion_tap      (seleccion_tap),
        .indice_tap         (indice_tap),
        .limpiar_acumulador (limpiar_acumulador),
        .habilitar_mac      (habilitar_mac),
        .ocupado            (ocupado),
        .terminado          (terminado)
    );

    typedef struct packed {
        logic [4:0] sel;
        logic [2:0] idx;
        logic       limp;
        logic       hab;
        logic       ocu;
        logic       term;
    } esperado_t;

    esperado_t cola[$];
    int        errores = 0;
    int        checks  = 0;
    int        pos     = 0;   // 0 idle, 1 clear, 2..N+1 tap (pos-2), N+2 done
    int        cyc     = 0;
    int        hab_cnt = 0;
    int        term_cyc[$];

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, esp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, push the expected outputs for this
    // cycle, compare on the falling edge, then advance the reference run.
    task automatic ciclo(input logic rst, input logic ini, input logic det);
        esperado_t e;
        int        tap;
        reset   = rst;
        iniciar = ini;
        detener = det;
        e.sel  = 5'b00001;
        e.idx  = 3'd0;
        e.limp = (pos == 1);
        e.ocu  = (pos != 0);
        e.term = (pos == N + 2);
        e.hab  = 1'b0;
        if (pos >= 2 && pos <= N + 1) begin
            tap   = pos - 2;
            e.sel = 5'(1 << tap);
            e.idx = 3'(tap);
            e.hab = !det;
        end
        cola.push_back(e);
        @(negedge clk);
        comprobar("queue_nonempty", 32'(cola.size() > 0), 1);
        if (cola.size() > 0) begin
            e = cola.pop_front();
            comprobar("seleccion_tap", 32'(seleccion_tap), 32'(e.sel));
            comprobar("indice_tap", 32'(indice_tap), 32'(e.idx));
            comprobar("limpiar_acumulador", 32'(limpiar_acumulador), 32'(e.limp));
            comprobar("habilitar_mac", 32'(habilitar_mac), 32'(e.hab));
            comprobar("ocupado", 32'(ocupado), 32'(e.ocu));
            comprobar("terminado", 32'(terminado), 32'(e.term));
        end
        comprobar("sel_onehot", 32'($onehot(seleccion_tap)), 1);
        comprobar("sel_eq_shift_idx", 32'(seleccion_tap == (5'd1 << indice_tap)), 1);
        if (habilitar_mac === 1'b1) hab_cnt++;
        if (terminado === 1'b1) term_cyc.push_back(cyc);
        @(posedge clk);
        if (rst)                pos = 0;
        else if (pos == 0)      pos = ini ? 1 : 0;
        else if (pos == 1)      pos = 2;
        else if (pos <= N + 1)  pos = det ? pos : pos + 1;
        else                    pos = 0;
        cyc++;
        #1;
    endtask

    task automatic limpiar_stats();
        hab_cnt = 0;
        term_cyc.delete();
    endtask

    initial begin
        int t0;
        reset   = 1'b1;
        iniciar = 1'b0;
        detener = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pos = 0;

        // Reset state held, then idle with stray detener ignored
        ciclo(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) ciclo(1'b0, 1'b0, (i % 3) == 0);

        // Single clean run
        limpiar_stats();
        t0 = cyc;
        ciclo(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) ciclo(1'b0, 1'b0, 1'b0);
        comprobar("run1_term_count", 32'(term_cyc.size()), 1);
        if (term_cyc.size() >= 1) comprobar("run1_term_cycle", 32'(term_cyc[0] - t0), 7);
        comprobar("run1_mac_cycles", 32'(hab_cnt), 5);

        // Stalls: cycle 1 (ignored in LIMPIAR), cycles 4-5 on tap 2, cycle 8 on tap 4
        limpiar_stats();
        t0 = cyc;
        ciclo(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 13; i++)
            ciclo(1'b0, 1'b0, (i == 1) || (i == 4) || (i == 5) || (i == 8));
        comprobar("stall_term_count", 32'(term_cyc.size()), 1);
        if (term_cyc.size() >= 1) comprobar("stall_term_cycle", 32'(term_cyc[0] - t0), 10);
        comprobar("stall_mac_cycles", 32'(hab_cnt), 5);

        // iniciar held: back-to-back runs every 8 cycles
        limpiar_stats();
        t0 = cyc;
        for (int i = 0; i < 24; i++) ciclo(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)  ciclo(1'b0, 1'b0, 1'b0);
        comprobar("held_term_count", 32'(term_cyc.size()), 3);
        if (term_cyc.size() >= 3) begin
            comprobar("held_first_term", 32'(term_cyc[0] - t0), 7);
            comprobar("held_period_a", 32'(term_cyc[1] - term_cyc[0]), 8);
            comprobar("held_period_b", 32'(term_cyc[2] - term_cyc[1]), 8);
        end
        comprobar("held_mac_cycles", 32'(hab_cnt), 15);

        // Reset during ACUMULAR at tap 3, reset+iniciar together, then clean run
        limpiar_stats();
        ciclo(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) ciclo(1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 1'b0, 1'b0);
        ciclo(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) ciclo(1'b0, 1'b0, 1'b0);
        comprobar("abort_no_term", 32'(term_cyc.size()), 0);
        limpiar_stats();
        t0 = cyc;
        ciclo(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) ciclo(1'b0, 1'b0, 1'b0);
        comprobar("rerun_term_count", 32'(term_cyc.size()), 1);
        if (term_cyc.size() >= 1) comprobar("rerun_term_cycle", 32'(term_cyc[0] - t0), 7);
        comprobar("rerun_mac_cycles", 32'(hab_cnt), 5);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
